// File: rtl/hc595_pkg.sv
// rtl/hc595_pkg.sv - gain codes, relay patterns, decode function and FSM states for the 74HC595 chain driver
package hc595_pkg;

    localparam logic [3:0] GAIN_X1   = 4'd0;
    localparam logic [3:0] GAIN_X2   = 4'd1;
    localparam logic [3:0] GAIN_X5   = 4'd2;
    localparam logic [3:0] GAIN_X10  = 4'd3;
    localparam logic [3:0] GAIN_X20  = 4'd4;
    localparam logic [3:0] GAIN_X50  = 4'd5;
    localparam logic [3:0] GAIN_X100 = 4'd6;

    localparam logic [7:0] PAT_X1   = 8'hFC;
    localparam logic [7:0] PAT_X2   = 8'h7D;
    localparam logic [7:0] PAT_X5   = 8'hBD;
    localparam logic [7:0] PAT_X10  = 8'hDD;
    localparam logic [7:0] PAT_X20  = 8'hDB;
    localparam logic [7:0] PAT_X50  = 8'hD7;
    localparam logic [7:0] PAT_X100 = 8'hCF;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_LOAD,
        ST_SH_LO,
        ST_SH_HI,
        ST_LATCH,
        ST_DONE
    } state_t;

    // Unused codes fall back to the safe x1 setting.
    function automatic logic [7:0] gain2pat(input logic [3:0] code);
        logic [7:0] pat;
        case (code)
            GAIN_X1:   pat = PAT_X1;
            GAIN_X2:   pat = PAT_X2;
            GAIN_X5:   pat = PAT_X5;
            GAIN_X10:  pat = PAT_X10;
            GAIN_X20:  pat = PAT_X20;
            GAIN_X50:  pat = PAT_X50;
            GAIN_X100: pat = PAT_X100;
            default:   pat = PAT_X1;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/hc595_bit_timer.sv
// rtl/hc595_bit_timer.sv - CLK_DIV down-counter giving the end-of-phase strobe for CLEAR/SH_LO/SH_HI/LATCH
module hc595_bit_timer #(
    parameter int CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    output logic o_end
);

    localparam int TW = $clog2(CLK_DIV + 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = TW'(CLK_DIV - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    // One extra count out of reset: the registered SRCLR_n still shows its
    // reset value in the first CLEAR cycle, so CLEAR runs CLK_DIV+1 cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= TW'(CLK_DIV);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_end = (cnt_q == '0);

endmodule

// File: rtl/hc595_chain_ctrl.sv
// rtl/hc595_chain_ctrl.sv - 74HC595 daisy-chain gain driver; HC595_AUTO_REFRESH_EN enables periodic idle refresh
module hc595_chain_ctrl
    import hc595_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int CLK_DIV        = 2,
    parameter int REFRESH_CYCLES = 1_000_000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [4*NUM_CH-1:0]   i_gain,
    input  logic                  i_force,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_SRCLR_n,
    output logic                  o_RCLK,
    output logic                  o_SER,
    output logic                  o_SRCLK
);

    localparam int CW = 8 * NUM_CH;
    localparam int BW = $clog2(CW);

    state_t          state_q, state_d;
    logic [CW-1:0]   frame;
    logic [CW-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]   commit_q, commit_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic            force_pend_q, force_pend_d;
    logic            tmr_load, tmr_end;
    logic            refresh_hit;
    logic            srclk_q, ser_q, rclk_q, srclr_n_q, busy_q, done_q;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_decode
        assign frame[8*ch +: 8] = gain2pat(i_gain[4*ch +: 4]);
    end

`ifdef HC595_AUTO_REFRESH_EN
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    logic [RW-1:0] idle_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idle_cnt_q <= '0;
        end else if (state_q == ST_IDLE && state_d == ST_IDLE) begin
            idle_cnt_q <= idle_cnt_q + RW'(1);
        end else begin
            idle_cnt_q <= '0;
        end
    end

    assign refresh_hit = (state_q == ST_IDLE) && (idle_cnt_q == RW'(REFRESH_CYCLES - 1));
`else
    // Refresh disabled; the parameter only keeps the interface uniform.
    assign refresh_hit = (REFRESH_CYCLES < 0);
`endif

    // Every timed phase begins with a state change, so that reloads the timer.
    assign tmr_load = (state_d != state_q);

    hc595_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (tmr_load),
        .o_end   (tmr_end)
    );

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        commit_d     = commit_q;
        bit_d        = bit_q;
        force_pend_d = force_pend_q | (i_force && state_q != ST_IDLE);
        case (state_q)
            ST_CLEAR: begin
                if (tmr_end) state_d = ST_LOAD;
            end
            ST_IDLE: begin
                if (frame != commit_q || i_force || force_pend_q || refresh_hit) begin
                    state_d      = ST_LOAD;
                    force_pend_d = 1'b0;
                end
            end
            ST_LOAD: begin
                shreg_d  = frame;
                commit_d = frame;
                bit_d    = BW'(CW - 1);
                state_d  = ST_SH_LO;
            end
            ST_SH_LO: begin
                if (tmr_end) state_d = ST_SH_HI;
            end
            ST_SH_HI: begin
                if (tmr_end) begin
                    shreg_d = {shreg_q[CW-2:0], 1'b0};
                    if (bit_q == '0) begin
                        state_d = ST_LATCH;
                    end else begin
                        bit_d   = bit_q - BW'(1);
                        state_d = ST_SH_LO;
                    end
                end
            end
            ST_LATCH: begin
                if (tmr_end) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_CLEAR;
            shreg_q      <= '0;
            commit_q     <= '0;
            bit_q        <= '0;
            force_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            commit_q     <= commit_d;
            bit_q        <= bit_d;
            force_pend_q <= force_pend_d;
        end
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            srclk_q   <= 1'b0;
            ser_q     <= 1'b0;
            rclk_q    <= 1'b0;
            srclr_n_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            srclk_q   <= (state_d == ST_SH_HI);
            ser_q     <= (state_d == ST_SH_LO || state_d == ST_SH_HI) && shreg_d[CW-1];
            rclk_q    <= (state_d == ST_LATCH);
            srclr_n_q <= (state_d != ST_CLEAR);
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign o_SRCLK   = srclk_q;
    assign o_SER     = ser_q;
    assign o_RCLK    = rclk_q;
    assign o_SRCLR_n = srclr_n_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;

endmodule
